alu_issue_ctrl: RTL

//  Issue stage that drives the ALU's ctrl/operand interface. Decodes a MIPS instruction

---
 rtl/alu_issue_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue stage: decodes a MIPS word into ALU ctrl/operands and holds it in a one-entry slot.
// Multiplies are held for MUL_LAT cycles after accept before out_valid_o rises.
module alu_issue_ctrl #(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [3:0]  ctrl_o,
    output logic [31:0] src1_o,
    output logic [31:0] src2_o,
    output logic [4:0]  shamt_o,
    output logic [15:0] imm_o,
    output logic [4:0]  wb_addr_o,
    output logic        wb_en_o,
    output logic        illegal_o
);

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpSll  = 4'b0011;
    localparam logic [3:0] OpSrlv = 4'b0100;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpMul  = 4'b1000;
    localparam logic [3:0] OpLui  = 4'b1001;
    localparam logic [3:0] OpOri  = 4'b1010;
    localparam logic [3:0] OpNor  = 4'b1100;

    localparam logic [3:0] MulWait = 4'(MUL_LAT - 1);
    localparam bit         MulHold = (MUL_LAT > 1);

    typedef enum logic [1:0] {StEmpty, StWait, StFull} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        accept;

    logic [3:0]  dec_ctrl;
    logic [31:0] dec_src1, dec_src2;
    logic [4:0]  dec_wb_addr;
    logic        dec_wb_en, dec_illegal, dec_mul;

    logic [5:0]  opcode, funct;
    logic [31:0] imm_sext;
    logic        unused_rs_field;

    assign opcode          = instr_i[31:26];
    assign funct           = instr_i[5:0];
    assign imm_sext        = {{16{instr_i[15]}}, instr_i[15:0]};
    assign unused_rs_field = ^instr_i[25:21];

    always_comb begin
        dec_ctrl    = OpAnd;
        dec_src1    = rs_data_i;
        dec_src2    = rt_data_i;
        dec_wb_addr = instr_i[15:11];
        dec_wb_en   = 1'b0;
        dec_illegal = 1'b0;
        dec_mul     = 1'b0;
        unique case (opcode)
            6'h00: begin
                dec_wb_en = 1'b1;
                unique case (funct)
                    6'h20: dec_ctrl = OpAdd;
                    6'h22: dec_ctrl = OpSub;
                    6'h24: dec_ctrl = OpAnd;
                    6'h25: dec_ctrl = OpOr;
                    6'h27: dec_ctrl = OpNor;
                    6'h2A: dec_ctrl = OpSlt;
                    6'h00: dec_ctrl = OpSll;
                    6'h06: dec_ctrl = OpSrlv;
                    6'h18: begin
                        dec_ctrl = OpMul;
                        dec_mul  = 1'b1;
                    end
                    default: begin
                        dec_wb_en   = 1'b0;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            6'h08, 6'h23, 6'h2B: begin
                dec_ctrl    = OpAdd;
                dec_src2    = imm_sext;
                dec_wb_addr = instr_i[20:16];
                dec_wb_en   = (opcode != 6'h2B);
            end
            6'h0D, 6'h0F: begin
                // The ALU takes the immediate from imm_o for these.
                dec_ctrl    = (opcode == 6'h0D) ? OpOri : OpLui;
                dec_src2    = '0;
                dec_wb_addr = instr_i[20:16];
                dec_wb_en   = 1'b1;
            end
            6'h04, 6'h05: begin
                dec_ctrl    = OpSub;
                dec_wb_addr = instr_i[20:16];
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Full slot with a consumer pop lets a new entry in during the same cycle.
    assign in_ready_o = !rst_i && ((state_q == StEmpty) || ((state_q == StFull) && out_ready_i));
    assign accept     = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StEmpty;
            cnt_q       <= '0;
            out_valid_o <= 1'b0;
            ctrl_o      <= '0;
            src1_o      <= '0;
            src2_o      <= '0;
            shamt_o     <= '0;
            imm_o       <= '0;
            wb_addr_o   <= '0;
            wb_en_o     <= 1'b0;
            illegal_o   <= 1'b0;
        end else if (accept) begin
            ctrl_o    <= dec_ctrl;
            src1_o    <= dec_src1;
            src2_o    <= dec_src2;
            shamt_o   <= instr_i[10:6];
            imm_o     <= instr_i[15:0];
            wb_addr_o <= dec_wb_addr;
            wb_en_o   <= dec_wb_en;
            illegal_o <= dec_illegal;
            if (dec_mul && MulHold) begin
                state_q     <= StWait;
                cnt_q       <= MulWait;
                out_valid_o <= 1'b0;
            end else begin
                state_q     <= StFull;
                out_valid_o <= 1'b1;
            end
        end else begin
            unique case (state_q)
                StWait: begin
                    if (cnt_q == 4'd1) begin
                        state_q     <= StFull;
                        cnt_q       <= '0;
                        out_valid_o <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StFull: begin
                    if (out_ready_i) begin
                        state_q     <= StEmpty;
                        out_valid_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
